// File: rtl/floating_point_multiplier.sv
// -----------------------------------------------------------------------------
// floating_point_multiplier
//
// Sequential radix-4 Booth multiplier for 32-bit signed two's-complement
// integers (the name is historical; no IEEE-754 handling is involved).
// There is no start strobe: any edge at which (x, y) differs from the captured
// operands reloads them and starts a fresh 16-iteration multiply. The result
// registers only change when a computation runs to completion.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   x, y     32-bit signed operands
//   product  64-bit signed registered product x*y
//   overflow registered; 1 when product lies outside the signed 32-bit range
// -----------------------------------------------------------------------------
module floating_point_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] product,
  output logic        overflow
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [31:0] x_cap_reg, x_cap_next;
  logic [31:0] y_cap_reg, y_cap_next;
  logic [63:0] acc_reg, acc_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [63:0] product_reg, product_next;
  logic        overflow_reg, overflow_next;

  logic [32:0] y_ext;        // y with the implicit y[-1] = 0 appended
  logic [5:0]  shamt;        // 2*i for iteration i
  logic [2:0]  triplet;
  logic [63:0] x_ext;
  logic [63:0] pp;
  logic [63:0] pp_shifted;
  logic [63:0] acc_sum;
  logic        operands_changed;

  assign y_ext            = {y_cap_reg, 1'b0};
  assign shamt            = {1'b0, cnt_reg, 1'b0};
  assign triplet          = y_ext[shamt +: 3];
  assign x_ext            = {{32{x_cap_reg[31]}}, x_cap_reg};
  assign operands_changed = (x != x_cap_reg) || (y != y_cap_reg);

  // Booth digit selection: digit = -2*b2 + b1 + b0 over {y[2i+1], y[2i], y[2i-1]}
  always_comb begin
    pp = 64'd0;
    case (triplet)
      3'b001, 3'b010: pp = x_ext;
      3'b011:         pp = x_ext << 1;
      3'b100:         pp = ~(x_ext << 1) + 64'd1;
      3'b101, 3'b110: pp = ~x_ext + 64'd1;
      default:        pp = 64'd0;
    endcase
  end

  assign pp_shifted = pp << shamt;
  assign acc_sum    = acc_reg + pp_shifted;

  // Next-state logic: an operand change always wins over an iteration, so an
  // in-flight multiply is abandoned and never reaches the result registers.
  always_comb begin
    state_next    = state_reg;
    x_cap_next    = x_cap_reg;
    y_cap_next    = y_cap_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    product_next  = product_reg;
    overflow_next = overflow_reg;

    if (operands_changed) begin
      x_cap_next = x;
      y_cap_next = y;
      acc_next   = 64'd0;
      cnt_next   = 4'd0;
      state_next = BUSY;
    end else if (state_reg == BUSY) begin
      acc_next = acc_sum;
      cnt_next = cnt_reg + 4'd1;
      if (cnt_reg == 4'd15) begin
        product_next  = acc_sum;
        // Fits in signed 32 bits only when bits 63..31 are all equal
        overflow_next = ~((&acc_sum[63:31]) | ~(|acc_sum[63:31]));
        state_next    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_cap_reg    <= 32'd0;
      y_cap_reg    <= 32'd0;
      acc_reg      <= 64'd0;
      cnt_reg      <= 4'd0;
      product_reg  <= 64'd0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_cap_reg    <= x_cap_next;
      y_cap_reg    <= y_cap_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      product_reg  <= product_next;
      overflow_reg <= overflow_next;
    end
  end

  assign product  = product_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_floating_point_multiplier.sv
// -----------------------------------------------------------------------------
// tb_floating_point_multiplier
//
// Directed, self-checking bench for floating_point_multiplier. Each scenario
// task drives operands and checks product/overflow against hand-computed
// values, including latency (result must appear exactly 16 edges after the
// load edge), abandonment on operand change, hold behaviour and reset.
// -----------------------------------------------------------------------------
module tb_floating_point_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] product;
  logic        overflow;

  int n_compared;
  int n_mismatched;

  // Last completed result the bench expects the DUT to be holding
  logic [63:0] held_product;
  logic        held_overflow;

  floating_point_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .product  (product),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset with zero operands, then confirm nothing starts while x=y=0
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    x   = 32'd0;
    y   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if (product !== 64'd0 || overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_state: product=%0d overflow=%0b required product=0 overflow=0",
               $signed(product), overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_compared++;
    if (product !== 64'd0 || overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL zero_after_reset: product=%0d overflow=%0b required product=0 overflow=0",
               $signed(product), overflow);
    end
    held_product  = 64'd0;
    held_overflow = 1'b0;
    $display("reset: product=%0d overflow=%0b", $signed(product), overflow);
  endtask

  // One multiply: old result must still be held at L+15, new one at L+16
  task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_p, input logic exp_o);
    @(negedge clk);
    x = a;
    y = b;
    repeat (16) @(posedge clk);
    #1;
    n_compared++;
    if (product !== held_product || overflow !== held_overflow) begin
      n_mismatched++;
      $display("FAIL %s_early: product=%0d overflow=%0b required held product=%0d overflow=%0b",
               name, $signed(product), overflow, $signed(held_product), held_overflow);
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (product !== exp_p || overflow !== exp_o) begin
      n_mismatched++;
      $display("FAIL %s: product=%0d overflow=%0b required product=%0d overflow=%0b",
               name, $signed(product), overflow, $signed(exp_p), exp_o);
    end
    held_product  = exp_p;
    held_overflow = exp_o;
    $display("mul %s: x=%0d y=%0d product=%0d overflow=%0b",
             name, $signed(a), $signed(b), $signed(product), overflow);
  endtask

  // Constant operands: outputs must stay put with no further computation
  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (product !== held_product || overflow !== held_overflow) begin
        n_mismatched++;
        $display("FAIL hold_cycle%0d: product=%0d overflow=%0b required product=%0d overflow=%0b",
                 i, $signed(product), overflow, $signed(held_product), held_overflow);
      end
    end
    $display("hold: product=%0d overflow=%0b", $signed(product), overflow);
  endtask

  // x=3,y=5 started, y changed to 7 eight edges in: 15 must never appear
  task automatic test_abandon();
    @(negedge clk);
    x = 32'd3;
    y = 32'd5;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (product !== held_product) begin
        n_mismatched++;
        $display("FAIL abandon_first%0d: product=%0d required %0d",
                 i, $signed(product), $signed(held_product));
      end
    end
    @(negedge clk);
    y = 32'd7;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      n_compared++;
      if (product !== held_product) begin
        n_mismatched++;
        $display("FAIL abandon_restart%0d: product=%0d required %0d",
                 i, $signed(product), $signed(held_product));
      end
    end
    @(posedge clk);
    #1;
    n_compared++;
    if (product !== 64'd21 || overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL abandon_result: product=%0d overflow=%0b required product=21 overflow=0",
               $signed(product), overflow);
    end
    held_product  = 64'd21;
    held_overflow = 1'b0;
    $display("abandon: product=%0d overflow=%0b", $signed(product), overflow);
  endtask

  // Reset in the middle of a computation clears result on the next edge
  task automatic test_reset_mid();
    @(negedge clk);
    x = 32'd7;
    y = 32'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_compared++;
    if (product !== 64'd0 || overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_mid: product=%0d overflow=%0b required product=0 overflow=0",
               $signed(product), overflow);
    end
    @(negedge clk);
    x   = 32'd0;
    y   = 32'd0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_compared++;
    if (product !== 64'd0 || overflow !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_mid_idle: product=%0d overflow=%0b required product=0 overflow=0",
               $signed(product), overflow);
    end
    held_product  = 64'd0;
    held_overflow = 1'b0;
    $display("reset_mid: product=%0d overflow=%0b", $signed(product), overflow);
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    rst           = 1'b1;
    x             = 32'd0;
    y             = 32'd0;
    held_product  = 64'd0;
    held_overflow = 1'b0;

    test_reset();
    test_mul("2x-5", 32'd2, -32'sd5, -64'sd10, 1'b0);
    test_mul("12x5", 32'd12, 32'd5, 64'd60, 1'b0);
    test_abandon();
    test_mul("12x5_again", 32'd12, 32'd5, 64'd60, 1'b0);
    test_mul("-20x-11", -32'sd20, -32'sd11, 64'd220, 1'b0);
    test_mul("100x0", 32'd100, 32'd0, 64'd0, 1'b0);
    test_mul("65535x1", 32'd65535, 32'd1, 64'd65535, 1'b0);
    test_mul("-4xmin", -32'sd4, 32'h8000_0000, 64'd8589934592, 1'b1);
    test_mul("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, -64'sd4611686016279904256, 1'b1);
    test_mul("minx1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 1'b0);
    test_mul("maxx1", 32'h7FFF_FFFF, 32'd1, 64'd2147483647, 1'b0);
    test_mul("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 64'd2147483648, 1'b1);
    test_mul("65536x32768", 32'd65536, 32'd32768, 64'd2147483648, 1'b1);
    test_mul("-65536x32768", -32'sd65536, 32'd32768, 64'hFFFF_FFFF_8000_0000, 1'b0);
    test_mul("minxmin", 32'h8000_0000, 32'h8000_0000, 64'd4611686018427387904, 1'b1);
    test_hold();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
